// File: rtl/rssi_link_pkg.sv
// Shared types and constants for the RSSI UART framer.
// Packet length follows RSSI_FRAMER_CSUM_EN (5 bytes with checksum, 4 without).
`default_nettype none

package rssi_link_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    SEQ  = 3'd2,
    HI   = 3'd3,
    LO   = 3'd4,
    CSUM = 3'd5
  } framer_state_t;

`ifdef RSSI_FRAMER_CSUM_EN
  localparam int PKT_LEN = 5;
`else
  localparam int PKT_LEN = 4;
`endif

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

`default_nettype wire

// File: rtl/rssi_uart_framer_if.sv
// Framer bus: dB result input, UartTx FIFO write port and status outputs.
// master = result source / FIFO side, slave = framer.
`default_nettype none

interface rssi_uart_framer_if #(
  parameter int DW = 16
);
  logic [DW-1:0] db_i;
  logic          valid_i;
  logic          fifo_full_i;
  logic [7:0]    data_o;
  logic          wr_en_o;
  logic          busy_o;
  logic [15:0]   drop_cnt_o;
  logic [7:0]    seq_o;

  modport master (
    output db_i, valid_i, fifo_full_i,
    input  data_o, wr_en_o, busy_o, drop_cnt_o, seq_o
  );

  modport slave (
    input  db_i, valid_i, fifo_full_i,
    output data_o, wr_en_o, busy_o, drop_cnt_o, seq_o
  );
endinterface

`default_nettype wire

// File: rtl/rssi_uart_framer.sv
// rssi_uart_framer: frames dB results as [SYNC, SEQ, DB_HI, DB_LO(, CSUM)] onto the UartTx FIFO.
// Macro RSSI_FRAMER_CSUM_EN adds the CSUM byte (SEQ ^ DB_HI ^ DB_LO).
`default_nettype none

module rssi_uart_framer
  import rssi_link_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter int         DW        = 16,
  parameter int         DECIMATE  = 1
) (
  input  wire logic          clk,
  input  wire logic          rst,
  rssi_uart_framer_if.slave  bus
);

  localparam int             DEC_W   = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;
  localparam logic [DEC_W-1:0] DEC_MAX = DEC_W'(DECIMATE - 1);

`ifdef RSSI_FRAMER_CSUM_EN
  localparam framer_state_t LAST_ST = CSUM;
`else
  localparam framer_state_t LAST_ST = LO;
`endif

  framer_state_t    state_q, state_d;
  logic [15:0]      word_q, word_d;
  logic             pend_valid_q, pend_valid_d;
  logic [15:0]      pend_word_q, pend_word_d;
  logic [DEC_W-1:0] dec_cnt_q, dec_cnt_d;
  logic [15:0]      drop_q, drop_d;
  logic [7:0]       seq_q, seq_d;
  logic [7:0]       data_q, data_d;
  logic             wr_en_q, wr_en_d;
  logic             busy_q, busy_d;

  logic [DW-1:0]    db_w;
  logic [15:0]      db_lo_w;
  logic             offered_w;
  logic             advance_w;

  assign db_w      = bus.db_i;
  assign db_lo_w   = db_w[15:0];
  assign offered_w = bus.valid_i && (dec_cnt_q == '0);
  assign advance_w = (state_q != IDLE) && !bus.fifo_full_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      word_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_word_q  <= '0;
      dec_cnt_q    <= '0;
      drop_q       <= '0;
      seq_q        <= '0;
      data_q       <= '0;
      wr_en_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      pend_valid_q <= pend_valid_d;
      pend_word_q  <= pend_word_d;
      dec_cnt_q    <= dec_cnt_d;
      drop_q       <= drop_d;
      seq_q        <= seq_d;
      data_q       <= data_d;
      wr_en_q      <= wr_en_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    logic pend_taken;
    logic idle_take;
    state_d      = state_q;
    word_d       = word_q;
    pend_word_d  = pend_word_q;
    dec_cnt_d    = dec_cnt_q;
    drop_d       = drop_q;
    seq_d        = seq_q;
    pend_taken   = 1'b0;
    idle_take    = 1'b0;

    if (bus.valid_i) begin
      dec_cnt_d = (dec_cnt_q == DEC_MAX) ? '0 : dec_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (pend_valid_q) begin
          word_d     = pend_word_q;
          pend_taken = 1'b1;
          state_d    = SYNC;
        end else if (offered_w) begin
          word_d    = db_lo_w;
          idle_take = 1'b1;
          state_d   = SYNC;
        end
      end
      SYNC: if (advance_w) state_d = SEQ;
      SEQ:  if (advance_w) state_d = HI;
      HI:   if (advance_w) state_d = LO;
`ifdef RSSI_FRAMER_CSUM_EN
      LO:   if (advance_w) state_d = CSUM;
`endif
      default: ;
    endcase

    // Leaving the final byte: chain straight into the buffered result if there is one.
    if (advance_w && state_q == LAST_ST) begin
      seq_d = seq_q + 8'd1;
      if (pend_valid_q) begin
        word_d     = pend_word_q;
        pend_taken = 1'b1;
        state_d    = SYNC;
      end else begin
        state_d = IDLE;
      end
    end

    pend_valid_d = pend_valid_q && !pend_taken;
    if (offered_w && !idle_take) begin
      if (!pend_valid_q || pend_taken) begin
        pend_valid_d = 1'b1;
        pend_word_d  = db_lo_w;
      end else if (drop_q != 16'hFFFF) begin
        drop_d = drop_q + 16'd1;
      end
    end

    busy_d = (state_d != IDLE) || pend_valid_d;
  end

  always_comb begin
    wr_en_d = 1'b0;
    data_d  = data_q;
    if (advance_w) begin
      wr_en_d = 1'b1;
      case (state_q)
        SYNC:    data_d = SYNC_BYTE;
        SEQ:     data_d = seq_q;
        HI:      data_d = word_q[15:8];
        LO:      data_d = word_q[7:0];
`ifdef RSSI_FRAMER_CSUM_EN
        CSUM:    data_d = seq_q ^ word_q[15:8] ^ word_q[7:0];
`endif
        default: data_d = data_q;
      endcase
    end
  end

  assign bus.data_o     = data_q;
  assign bus.wr_en_o    = wr_en_q;
  assign bus.busy_o     = busy_q;
  assign bus.drop_cnt_o = drop_q;
  assign bus.seq_o      = seq_q;

endmodule

`default_nettype wire

// File: tb/tb_rssi_uart_framer.sv
// Self-checking bench for rssi_uart_framer: constant vector table, directed corner
// sequences and random traffic checked cycle by cycle against a packet-queue model.
`default_nettype none

module tb_rssi_uart_framer;
  import rssi_link_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rssi_uart_framer_if #(.DW(16)) bus ();
  rssi_uart_framer_if #(.DW(16)) bus2 ();

  rssi_uart_framer #(.SYNC_BYTE(8'hA5), .DW(16), .DECIMATE(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  rssi_uart_framer #(.SYNC_BYTE(8'hA5), .DW(16), .DECIMATE(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference model: each accepted result becomes a queue of bytes still to be written.
  logic [7:0]  m_q[$];
  bit          m_pend;
  logic [15:0] m_pend_w;
  logic [7:0]  m_seq;
  logic [15:0] m_drop;
  bit          m_wr;
  logic [7:0]  m_data;

  function automatic void pkt_bytes(input logic [7:0] s, input logic [15:0] w,
                                    inout logic [7:0] q[$]);
    q.push_back(8'hA5);
    q.push_back(s);
    q.push_back(w[15:8]);
    q.push_back(w[7:0]);
    if (PKT_LEN == 5) q.push_back(s ^ w[15:8] ^ w[7:0]);
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_pend = 0; m_pend_w = '0; m_seq = '0; m_drop = '0; m_wr = 0; m_data = '0;
  endfunction

  function automatic void model_step(bit full, bit valid, logic [15:0] db);
    bit was_active, finished, started;
    was_active = (m_q.size() != 0);
    finished = 0; started = 0; m_wr = 0;
    if (was_active && !full) begin
      m_wr = 1;
      m_data = m_q.pop_front();
      if (m_q.size() == 0) begin finished = 1; m_seq++; end
    end
    if (m_pend && ((was_active && finished) || !was_active)) begin
      pkt_bytes(m_seq, m_pend_w, m_q);
      m_pend = 0; started = 1;
    end
    if (valid) begin
      if (!was_active && !started) pkt_bytes(m_seq, db, m_q);
      else if (!m_pend) begin m_pend = 1; m_pend_w = db; end
      else if (m_drop != 16'hFFFF) m_drop++;
    end
  endfunction

  task automatic step(input bit full, input bit valid, input logic [15:0] db,
                      input bit do_rst = 0);
    bus.fifo_full_i = full;
    bus.valid_i     = valid;
    bus.db_i        = db;
    rst             = do_rst;
    @(posedge clk);
    #1;
    if (do_rst) begin
      model_reset();
      check("rst_data", {24'd0, bus.data_o}, 32'd0);
    end else begin
      model_step(full, valid, db);
    end
    check("wr_en", {31'd0, bus.wr_en_o}, {31'd0, m_wr});
    if (m_wr) check("data", {24'd0, bus.data_o}, {24'd0, m_data});
    check("busy", {31'd0, bus.busy_o}, {31'd0, (m_q.size() != 0) || m_pend});
    check("drop_cnt", {16'd0, bus.drop_cnt_o}, {16'd0, m_drop});
    check("seq", {24'd0, bus.seq_o}, {24'd0, m_seq});
  endtask

  typedef struct {
    bit          full;
    bit          valid;
    logic [15:0] db;
    bit          exp_wr;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit f, bit v, logic [15:0] d, bit ew, logic [7:0] ed);
    vec_t r;
    r.full = f; r.valid = v; r.db = d; r.exp_wr = ew; r.exp_data = ed;
    vecs.push_back(r);
  endfunction

  logic [7:0] got2[$];
  logic [7:0] exp2[$];
  int         wcnt;
  logic [7:0] seqb;

  initial begin
    bus.db_i = '0; bus.valid_i = 0; bus.fifo_full_i = 0;
    bus2.db_i = '0; bus2.valid_i = 0; bus2.fifo_full_i = 0;
    model_reset();

    // Packet 1: 1234 -> A5 00 12 34 (26). Packet 2: 5678 with FIFO full for 5 cycles after SYNC.
    add(0, 0, 16'h0000, 0, 8'h00);
    add(0, 1, 16'h1234, 0, 8'h00);
    add(0, 0, 16'h0000, 1, 8'hA5);
    add(0, 0, 16'h0000, 1, 8'h00);
    add(0, 0, 16'h0000, 1, 8'h12);
    add(0, 0, 16'h0000, 1, 8'h34);
`ifdef RSSI_FRAMER_CSUM_EN
    add(0, 0, 16'h0000, 1, 8'h26);
`endif
    add(0, 0, 16'h0000, 0, 8'h00);
    add(0, 1, 16'h5678, 0, 8'h00);
    add(0, 0, 16'h0000, 1, 8'hA5);
    for (int i = 0; i < 5; i++) add(1, 0, 16'h0000, 0, 8'h00);
    add(0, 0, 16'h0000, 1, 8'h01);
    add(0, 0, 16'h0000, 1, 8'h56);
    add(0, 0, 16'h0000, 1, 8'h78);
`ifdef RSSI_FRAMER_CSUM_EN
    add(0, 0, 16'h0000, 1, 8'h2F);
`endif
    add(0, 0, 16'h0000, 0, 8'h00);

    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("reset_busy", {31'd0, bus.busy_o}, 32'd0);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].full, vecs[i].valid, vecs[i].db);
      check("vec_wr", {31'd0, bus.wr_en_o}, {31'd0, vecs[i].exp_wr});
      if (vecs[i].exp_wr) check("vec_data", {24'd0, bus.data_o}, {24'd0, vecs[i].exp_data});
    end
    check("vec_seq", {24'd0, bus.seq_o}, 32'd2);

    // Three strobes back to back: send, buffer, drop; then two packets with no gap.
    step(0, 1, 16'hAAAA);
    step(0, 1, 16'hBBBB);
    step(0, 1, 16'hCCCC);
    check("three_drop", {16'd0, bus.drop_cnt_o}, 32'd1);
    for (int i = 0; i < 2 * PKT_LEN - 2; i++) begin
      step(0, 0, 0);
      check("nogap_wr", {31'd0, bus.wr_en_o}, 32'd1);
    end
    step(0, 0, 0);
    check("after_two_wr", {31'd0, bus.wr_en_o}, 32'd0);

    // Reset while the HI byte is being written.
    step(0, 1, 16'hDEAD);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0, 1);
    check("rst_mid_wr", {31'd0, bus.wr_en_o}, 32'd0);
    check("rst_mid_seq", {24'd0, bus.seq_o}, 32'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    step(0, 1, 16'hBEEF);
    step(0, 0, 0);
    step(0, 0, 0);
    check("post_rst_seq_byte", {24'd0, bus.data_o}, 32'd0);
    for (int i = 0; i < PKT_LEN; i++) step(0, 0, 0);

    // DECIMATE=4 instance: 8 strobes, only strobes 1 and 5 are framed.
    pkt_bytes(8'h00, 16'h1001, exp2);
    pkt_bytes(8'h01, 16'h1005, exp2);
    for (int s = 1; s <= 8; s++) begin
      for (int c = 0; c < 8; c++) begin
        bus2.valid_i = (c == 0);
        bus2.db_i    = 16'h1000 + 16'(s);
        step(0, 0, 0);
        if (bus2.wr_en_o) got2.push_back(bus2.data_o);
      end
    end
    bus2.valid_i = 0;
    check("dec_nbytes", got2.size(), exp2.size());
    for (int i = 0; i < exp2.size() && i < got2.size(); i++)
      check("dec_byte", {24'd0, got2[i]}, {24'd0, exp2[i]});
    check("dec_drop", {16'd0, bus2.drop_cnt_o}, 32'd0);

    // 257 packets: SEQ byte runs 00..FF then wraps to 00.
    step(0, 0, 0, 1);
    for (int p = 0; p < 257; p++) begin
      step(0, 1, 16'(p * 7));
      wcnt = 0;
      for (int i = 0; i < PKT_LEN; i++) begin
        step(0, 0, 0);
        if (bus.wr_en_o) begin
          if (wcnt == 1) seqb = bus.data_o;
          wcnt++;
        end
      end
      check("seq_byte", {24'd0, seqb}, p % 256);
    end
    check("seq_wrap", {24'd0, bus.seq_o}, 32'd1);

    // Forced drops with FIFO stuck full: counter saturates at FFFF.
    step(1, 1, 16'h0101);
    step(1, 1, 16'h0202);
    for (int i = 0; i < 65540; i++) step(1, 1, 16'h0303);
    check("drop_sat", {16'd0, bus.drop_cnt_o}, 32'h0000FFFF);

    // Random traffic against the model.
    step(0, 0, 0, 1);
    for (int i = 0; i < 2000; i++)
      step(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 4), 16'($urandom));
    for (int i = 0; i < 40; i++) step(0, 0, 0);
    check("final_idle", {31'd0, bus.busy_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
